// File: rtl/sap_pkg.sv
// Shared opcodes, control-word bit positions and sequencer state encoding
// for the SAP control sequencer.
package sap_pkg;

  localparam int CTRL_W = 15;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_NOP = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int B_CP   = 14;
  localparam int B_EP   = 13;
  localparam int B_LP   = 12;
  localparam int B_NLMA = 11;
  localparam int B_NLMD = 10;
  localparam int B_NCE  = 9;
  localparam int B_NLR  = 8;
  localparam int B_NLI  = 7;
  localparam int B_NEI  = 6;
  localparam int B_NLA  = 5;
  localparam int B_EA   = 4;
  localparam int B_SUB  = 3;
  localparam int B_EU   = 2;
  localparam int B_NLB  = 1;
  localparam int B_NLO  = 0;

  // All active-low strobes high, all active-high strobes low.
  localparam logic [CTRL_W-1:0] CTRL_INACTIVE = 15'h0FE3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_HALT
  } sap_state_t;

endpackage

// File: rtl/sap_microcode.sv
// Combinational microcode ROM: maps the current T-state and opcode to the
// control word plus end-of-instruction and enter-halt flags.
module sap_microcode
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter bit EXT_ISA  = 1'b1
) (
  input  sap_state_t          i_state,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_cf,
  input  logic                i_zf,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic                o_end,
  output logic                o_halt
);

  logic       w_upper_zero;
  logic [3:0] w_op;

  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign w_upper_zero = ~|i_opcode[OPCODE_W-1:4];
    end else begin : g_narrow_op
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  // Anything outside the enabled instruction set collapses to a NOP.
  always_comb begin
    w_op = i_opcode[3:0];
    if (!w_upper_zero)
      w_op = OP_NOP;
    else if (!EXT_ISA && (w_op == OP_LDI || w_op == OP_JC || w_op == OP_JZ))
      w_op = OP_NOP;
  end

  always_comb begin
    o_ctrl = CTRL_INACTIVE;
    o_end  = 1'b0;
    o_halt = 1'b0;
    case (i_state)
      ST_T0: begin
        o_ctrl[B_EP]   = 1'b1;
        o_ctrl[B_NLMA] = 1'b0;
      end
      ST_T1: o_ctrl[B_CP] = 1'b1;
      ST_T2: begin
        o_ctrl[B_NCE] = 1'b0;
        o_ctrl[B_NLI] = 1'b0;
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
          OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: o_end = 1'b0;
          default:                              o_end = 1'b1;
        endcase
      end
      ST_T3: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl[B_NEI]  = 1'b0;
            o_ctrl[B_NLMA] = 1'b0;
          end
          OP_LDI: begin
            o_ctrl[B_NEI] = 1'b0;
            o_ctrl[B_NLA] = 1'b0;
            o_end         = 1'b1;
          end
          OP_JMP: begin
            o_ctrl[B_NEI] = 1'b0;
            o_ctrl[B_LP]  = 1'b1;
            o_end         = 1'b1;
          end
          OP_JC, OP_JZ: begin
            // Untaken branch leaves the word fully inactive.
            if ((w_op == OP_JC) ? i_cf : i_zf) begin
              o_ctrl[B_NEI] = 1'b0;
              o_ctrl[B_LP]  = 1'b1;
            end
            o_end = 1'b1;
          end
          OP_OUT: begin
            o_ctrl[B_EA]  = 1'b1;
            o_ctrl[B_NLO] = 1'b0;
            o_end         = 1'b1;
          end
          OP_HLT:  o_halt = 1'b1;
          default: o_end  = 1'b1;
        endcase
      end
      ST_T4: begin
        case (w_op)
          OP_LDA: begin
            o_ctrl[B_NCE] = 1'b0;
            o_ctrl[B_NLA] = 1'b0;
            o_end         = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl[B_NCE] = 1'b0;
            o_ctrl[B_NLB] = 1'b0;
          end
          OP_STA: begin
            o_ctrl[B_EA]   = 1'b1;
            o_ctrl[B_NLMD] = 1'b0;
          end
          default: o_end = 1'b1;
        endcase
      end
      ST_T5: begin
        o_end = 1'b1;
        case (w_op)
          OP_ADD, OP_SUB: begin
            o_ctrl[B_EU]  = 1'b1;
            o_ctrl[B_SUB] = (w_op == OP_SUB);
            o_ctrl[B_NLA] = 1'b0;
          end
          OP_STA:  o_ctrl[B_NLR] = 1'b0;
          default: o_ctrl = CTRL_INACTIVE;
        endcase
      end
      ST_T6, ST_T7: o_end = 1'b1;
      default: o_end = 1'b0;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// T-state sequencer for the SAP CPU: state register, single-step gating,
// halt handling and status outputs around the microcode ROM.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int NUM_T    = 6,
  parameter int T_W      = $clog2(NUM_T),
  parameter bit EXT_ISA  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                cf,
  input  logic                zf,
  input  logic                step_mode,
  input  logic                step,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [T_W-1:0]      t_state,
  output logic                halted
);

  sap_state_t        r_state;
  sap_state_t        w_next;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_end;
  logic              w_halt;
  logic              w_advance;
  logic              w_is_t;
  logic              w_last;
  logic [3:0]        w_t_idx;

  sap_microcode #(
    .OPCODE_W(OPCODE_W),
    .EXT_ISA (EXT_ISA)
  ) u_microcode (
    .i_state (r_state),
    .i_opcode(opcode),
    .i_cf    (cf),
    .i_zf    (zf),
    .o_ctrl  (w_ctrl),
    .o_end   (w_end),
    .o_halt  (w_halt)
  );

  assign w_advance = !step_mode || step;
  assign w_is_t    = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign w_t_idx   = w_is_t ? (4'(r_state) - 4'(ST_T0)) : 4'd0;
  // Short configurations truncate longer instructions at the last T-state.
  assign w_last    = (w_t_idx == 4'(NUM_T - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_advance) w_next = ST_T0;
      ST_HALT: w_next = ST_HALT;
      default: begin
        if (w_advance) begin
          if (w_halt)
            w_next = ST_HALT;
          else if (w_end || w_last)
            w_next = ST_T0;
          else
            w_next = sap_state_t'(4'(r_state) + 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  assign ctrl    = w_ctrl;
  assign t_state = w_t_idx[T_W-1:0];
  assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a monitor
// pops and compares them on the falling edge.
module tb_sap_control_sequencer;

  localparam logic [14:0] C_IN  = 15'h0FE3;
  localparam logic [14:0] C_T0  = 15'h27E3;
  localparam logic [14:0] C_T1  = 15'h4FE3;
  localparam logic [14:0] C_T2  = 15'h0D63;
  localparam logic [14:0] C_MAR = 15'h07A3;
  localparam logic [14:0] C_JMP = 15'h1FA3;

  typedef struct {
    string       name;
    bit          sel;
    logic [14:0] ctrl;
    logic [2:0]  t;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, cf, zf, step_mode, step;
  logic [3:0]  opcode;
  logic [14:0] ctrl0, ctrl1;
  logic [2:0]  t0, t1;
  logic        h0, h1;

  exp_t q[$];
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;

  logic [14:0] s_ctrl [8];
  logic [2:0]  s_t    [8];

  sap_control_sequencer #(.OPCODE_W(4), .NUM_T(6), .EXT_ISA(1'b1)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
    .step_mode(step_mode), .step(step),
    .ctrl(ctrl0), .t_state(t0), .halted(h0)
  );

  sap_control_sequencer #(.OPCODE_W(4), .NUM_T(6), .EXT_ISA(1'b0)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
    .step_mode(step_mode), .step(step),
    .ctrl(ctrl1), .t_state(t1), .halted(h1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic x(input string nm, input bit sel, input logic [14:0] c,
                   input logic [2:0] t, input logic h);
    exp_t e;
    e.name = nm; e.sel = sel; e.ctrl = c; e.t = t; e.h = h;
    q.push_back(e);
  endtask

  task automatic fetch12(input string nm);
    tick(); x({nm, "_t1"}, 1'b0, C_T1, 3'd1, 1'b0);
    tick(); x({nm, "_t2"}, 1'b0, C_T2, 3'd2, 1'b0);
  endtask

  // Monitor: compares every queued expectation against the selected DUT.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        logic [14:0] ac;
        logic [2:0]  at;
        logic        ah;
        m_e = q.pop_front();
        ac = m_e.sel ? ctrl1 : ctrl0;
        at = m_e.sel ? t1 : t0;
        ah = m_e.sel ? h1 : h0;
        total++;
        if (ac !== m_e.ctrl || at !== m_e.t || ah !== m_e.h) begin
          bad++;
          $display("FAIL %s dut%0d: got ctrl=%h t=%0d halted=%b, want ctrl=%h t=%0d halted=%b",
                   m_e.name, m_e.sel, ac, at, ah, m_e.ctrl, m_e.t, m_e.h);
        end else begin
          $display("ok   %s dut%0d: ctrl=%h t=%0d halted=%b",
                   m_e.name, m_e.sel, ac, at, ah);
        end
      end
    end
  end

  initial begin
    s_ctrl[0] = C_IN;  s_t[0] = 3'd0;
    s_ctrl[1] = C_T0;  s_t[1] = 3'd0;
    s_ctrl[2] = C_T1;  s_t[2] = 3'd1;
    s_ctrl[3] = C_T2;  s_t[3] = 3'd2;
    s_ctrl[4] = C_MAR; s_t[4] = 3'd3;
    s_ctrl[5] = 15'h0DE1; s_t[5] = 3'd4;
    s_ctrl[6] = 15'h0FC7; s_t[6] = 3'd5;
    s_ctrl[7] = C_T0;  s_t[7] = 3'd0;

    rst = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(); x("rst_idle", 1'b0, C_IN, 3'd0, 1'b0); x("rst_idle", 1'b1, C_IN, 3'd0, 1'b0);
    rst = 1'b0;

    // LDA free-run
    tick(); x("lda_t0", 1'b0, C_T0, 3'd0, 1'b0);
    fetch12("lda");
    tick(); x("lda_t3", 1'b0, C_MAR, 3'd3, 1'b0);
    tick(); x("lda_t4", 1'b0, 15'h0DC3, 3'd4, 1'b0);
    tick(); x("lda_wrap", 1'b0, C_T0, 3'd0, 1'b0);

    opcode = 4'h6; cf = 1'b0;
    fetch12("jc_nt");
    tick(); x("jc_nt_t3", 1'b0, C_IN, 3'd3, 1'b0);
    tick(); x("jc_nt_t0", 1'b0, C_T0, 3'd0, 1'b0);

    cf = 1'b1;
    fetch12("jc_tk");
    tick(); x("jc_tk_t3", 1'b0, C_JMP, 3'd3, 1'b0);
    tick(); x("jc_tk_t0", 1'b0, C_T0, 3'd0, 1'b0);

    cf = 1'b0; zf = 1'b1; opcode = 4'h7;
    fetch12("jz_tk");
    tick(); x("jz_tk_t3", 1'b0, C_JMP, 3'd3, 1'b0);
    tick(); x("jz_tk_t0", 1'b0, C_T0, 3'd0, 1'b0);
    zf = 1'b0;

    opcode = 4'h5;
    fetch12("jmp");
    tick(); x("jmp_t3", 1'b0, C_JMP, 3'd3, 1'b0);
    tick(); x("jmp_t0", 1'b0, C_T0, 3'd0, 1'b0);

    opcode = 4'hE;
    fetch12("out");
    tick(); x("out_t3", 1'b0, 15'h0FF2, 3'd3, 1'b0);
    tick(); x("out_t0", 1'b0, C_T0, 3'd0, 1'b0);

    opcode = 4'h4;
    fetch12("ldi");
    tick(); x("ldi_t3", 1'b0, 15'h0F83, 3'd3, 1'b0);
    tick(); x("ldi_t0", 1'b0, C_T0, 3'd0, 1'b0);

    opcode = 4'h9;
    fetch12("nop");
    tick(); x("nop_t0", 1'b0, C_T0, 3'd0, 1'b0);

    opcode = 4'h2;
    fetch12("sub");
    tick(); x("sub_t3", 1'b0, C_MAR, 3'd3, 1'b0);
    tick(); x("sub_t4", 1'b0, 15'h0DE1, 3'd4, 1'b0);
    tick(); x("sub_t5", 1'b0, 15'h0FCF, 3'd5, 1'b0);
    tick(); x("sub_t0", 1'b0, C_T0, 3'd0, 1'b0);

    // STA interrupted by reset in T4: nLr must never appear
    opcode = 4'h3;
    fetch12("sta");
    tick(); x("sta_t3", 1'b0, C_MAR, 3'd3, 1'b0);
    tick(); x("sta_t4", 1'b0, 15'h0BF3, 3'd4, 1'b0);
    rst = 1'b1;
    tick(); x("sta_rst", 1'b0, C_IN, 3'd0, 1'b0); x("sta_rst", 1'b1, C_IN, 3'd0, 1'b0);
    rst = 1'b0;

    // JC on both instances: NOP timing when the extended ISA is off
    opcode = 4'h6; cf = 1'b1;
    tick(); x("ext_t0", 1'b0, C_T0, 3'd0, 1'b0); x("noext_t0", 1'b1, C_T0, 3'd0, 1'b0);
    tick(); x("ext_t1", 1'b0, C_T1, 3'd1, 1'b0); x("noext_t1", 1'b1, C_T1, 3'd1, 1'b0);
    tick(); x("ext_t2", 1'b0, C_T2, 3'd2, 1'b0); x("noext_t2", 1'b1, C_T2, 3'd2, 1'b0);
    tick(); x("ext_t3", 1'b0, C_JMP, 3'd3, 1'b0); x("noext_wrap", 1'b1, C_T0, 3'd0, 1'b0);
    tick(); x("ext_t0b", 1'b0, C_T0, 3'd0, 1'b0); x("noext_t1b", 1'b1, C_T1, 3'd1, 1'b0);
    tick(); x("ext_t1b", 1'b0, C_T1, 3'd1, 1'b0); x("noext_t2b", 1'b1, C_T2, 3'd2, 1'b0);
    tick(); x("ext_t2b", 1'b0, C_T2, 3'd2, 1'b0); x("noext_wrap2", 1'b1, C_T0, 3'd0, 1'b0);

    // HLT: sticky halt that ignores step controls, cleared only by reset
    rst = 1'b1; cf = 1'b0;
    tick(); x("hlt_rst", 1'b0, C_IN, 3'd0, 1'b0);
    rst = 1'b0; opcode = 4'hF;
    tick(); x("hlt_t0", 1'b0, C_T0, 3'd0, 1'b0);
    fetch12("hlt");
    tick(); x("hlt_t3", 1'b0, C_IN, 3'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  step_mode = 1'b1;
      if (i == 10) step = 1'b1;
      tick(); x($sformatf("halt_%0d", i), 1'b0, C_IN, 3'd0, 1'b1);
    end
    step = 1'b0; step_mode = 1'b0; rst = 1'b1;
    tick(); x("halt_clr", 1'b0, C_IN, 3'd0, 1'b0);

    // Single-step ADD: one pulse every third cycle
    rst = 1'b0; step_mode = 1'b1; opcode = 4'h1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        step = 1'b1;
        tick(); x($sformatf("step_s%0d_p", k), 1'b0, s_ctrl[k], s_t[k], 1'b0);
        step = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
        tick(); x($sformatf("step_s%0d_h%0d", k, j), 1'b0, s_ctrl[k], s_t[k], 1'b0);
      end
    end
    step_mode = 1'b0;

    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Parametrised T-state sequencer and microcode decoder for the 8-bit SAP-style CPU. It drives the 15-bit control word that steers the program counter, MAR/RAM, instruction, A, B and output registers and the ALU. Relative to the first-generation control block it adds several features:
- conditional jumps on the registered ALU carry and zero flags;
- variable-length instructions that finish early;
- a sticky halt state;
- single-step debug mode;
- a parameter that switches the extended instruction set on or off.

## Interface
Parameters:
- OPCODE_W, 4: opcode width. Only the low 4 bits are decoded; extra upper bits must be 0, otherwise the opcode is treated as NOP.
- NUM_T, 6: maximum T-states per instruction. Legal range 4..8.
- T_W, $clog2(NUM_T): width of the t_state output.
- EXT_ISA, 1: 1 enables LDI, JC and JZ; 0 decodes those opcodes as NOP.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  instruction-register opcode field.
- cf  in  1  registered ALU carry flag.
- zf  in  1  registered ALU zero flag.
- step_mode  in  1  1 selects single-step operation.
- step  in  1  advance request in step mode. Sampled level, one state per cycle high.
- ctrl  out  15  control word, bits [14:0] = Cp Ep Lp nLma nLmd nCE nLr nLi nEi nLa Ea sub Eu nLb nLo.
- t_state  out  T_W  current T-state index. Reads 0 in IDLE and in HALT.
- halted  out  1  high while in HALT.

## Operation
- States: IDLE, T0..T(NUM_T-1), HALT.
- Reset enters IDLE. IDLE outputs the inactive word for one cycle, then moves to T0.
- Inactive word is 15'h0FE3: every active-low bit is 1, every active-high bit is 0. Only the bits listed for a state deviate from it.
- ctrl is a combinational decode of the state register, opcode, cf and zf.
- Fetch (all opcodes):
  - T0: Ep, nLma=0.
  - T1: Cp.
  - T2: nCE=0, nLi=0.
- Execute: each line lists the T-states, then the last state of the instruction (END). After END the sequencer goes to T0.
  - 0 LDA: T3 nEi=0, nLma=0; T4 nCE=0, nLa=0. END T4.
  - 1 ADD: T3 nEi=0, nLma=0; T4 nCE=0, nLb=0; T5 Eu, nLa=0. END T5.
  - 2 SUB: same as ADD, with sub asserted in T5 only. END T5.
  - 3 STA: T3 nEi=0, nLma=0; T4 Ea, nLmd=0; T5 nLr=0. END T5.
  - 4 LDI: T3 nEi=0, nLa=0. END T3.
  - 5 JMP: T3 nEi=0, Lp. END T3.
  - 6 JC: T3 nEi=0, Lp if cf=1; otherwise the inactive word. END T3.
  - 7 JZ: same as JC, using zf. END T3.
  - E OUT: T3 Ea, nLo=0. END T3.
  - F HLT: T3 inactive word, then HALT.
  - All other opcodes are NOP. END T2.
- HALT outputs the inactive word and holds until rst. step and step_mode are ignored while halted.
- Step mode gating:
  - When step_mode=1, the state advances only in a cycle where step=1. Otherwise the current state and its ctrl word are held.
  - IDLE→T0 is also gated by step.
  - step_mode may change at any cycle and takes effect on the next edge.
- With NUM_T < 6, any execute state at index ≥ NUM_T is skipped: the instruction ends at T(NUM_T-1).

## Timing
- Free-running mode: one state per clock.
  - Instruction length: NOP 3 cycles; LDI/JMP/JC/JZ/OUT 4; LDA 5; ADD/SUB/STA 6.
  - HLT reaches HALT 4 cycles after its T0.
- cf and zf are sampled combinationally in T3 of JC/JZ. The ALU flags must be stable from the previous edge.
- rst high at any edge, including mid-instruction or in HALT, gives state IDLE after that edge.
  - During the following cycle: ctrl=15'h0FE3, t_state=0, halted=0.
- rst has priority over step.

## Structure
- Package sap_pkg holds:
  - opcode localparams;
  - control-bit index localparams;
  - CTRL_INACTIVE = 15'h0FE3;
  - the state enum.
- Sub-module sap_microcode: a purely combinational ROM mapping (state, opcode, cf, zf, EXT_ISA) to (ctrl, end_flag, halt_flag).
- The top level keeps the state register, step gating and status outputs.

## Test plan
- Reset then free-run with opcode=4'h0 (LDA):
  - ctrl sequence 0FE3, then T0 with Ep=1 and nLma=0, then T1, T2, T3, T4;
  - T0 again 6 cycles after reset release.
- JC with cf=0 and then cf=1:
  - Lp=0 in T3 for the first;
  - Lp=1 and nEi=0 in T3 for the second;
  - both return to T0 on the next cycle.
- EXT_ISA=0 with opcode 4'h6: NOP timing, T2→T0, and Lp is never asserted.
- HLT: halted=1 from cycle 4 onward, ctrl=0FE3 for 20 cycles. Asserting rst gives IDLE with halted=0.
- step_mode=1 with ADD and one step pulse every 3 cycles: ctrl holds each word for 3 cycles; the full instruction takes 6 pulses.
- rst asserted in T4 of STA: nLr is never asserted, and the next cycle shows ctrl=0FE3.
